seg_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment display controller, successor to the fixed 8-digit scanner.

---
 rtl/seg_scan_ctrl_pkg.sv | 17 +
 rtl/seg_scan_ctrl_font.sv | 11 +
 rtl/seg_scan_ctrl.sv | 106 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: off pattern, segment bit
// positions and the active-high hex font (gfedcba).
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Entry [n] is the glyph for hex digit n; b and d are lowercase.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_scan_ctrl_font.sv
// Hex nibble to active-high 7-segment pattern (gfedcba), purely combinational.
module seg_font
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_FONT[nibble_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner: prescaled digit scan, frame-coherent snapshot,
// leading-zero suppression, per-digit blanking and PWM brightness; registered outputs.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned DIV_W    = 17,
  parameter int unsigned BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   datas,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [7:0]            display_data,
  output logic [DIGITS-1:0]     display_en
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIV_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       first_q;
  logic [DIGITS-1:0][3:0]     nib_q;
  logic [DIGITS-1:0]          dp_q, blank_q;
  logic                       lz_q;
  logic [7:0]                 data_q, data_d;
  logic [DIGITS-1:0]          en_q, en_d;

  logic                       tick, last, snap, on, visible, zero_run;
  logic [BRIGHT_W-1:0]        phase;
  logic [DIGITS-1:0]          supp;
  logic [6:0]                 seg;

  seg_font u_font (
    .nibble_i (nib_q[idx_q]),
    .seg_o    (seg)
  );

  always_comb begin
    tick  = &cnt_q;
    last  = (idx_q == IDX_W'(DIGITS - 1));
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = last ? '0 : idx_q + 1'b1;
    snap  = first_q | (tick & last);
  end

  // Walk from the most significant digit down; a digit stays suppressed only while
  // every nibble from it upward is zero. A lit dp rescues just its own digit.
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      zero_run = zero_run & (nib_q[DIGITS-1-i] == 4'h0);
      if (lz_q && zero_run && (i != DIGITS - 1) && !dp_q[DIGITS-1-i])
        supp[DIGITS-1-i] = 1'b1;
    end
  end

  // cnt_q == 0 is the first cycle of a new slot; keeping it dark gives the anti-ghost gap.
  always_comb begin
    phase   = cnt_q[DIV_W-1 -: BRIGHT_W];
    on      = (&brightness) | (phase < brightness);
    visible = on & ~blank_q[idx_q] & ~supp[idx_q] & (cnt_q != '0);
    en_d    = '1;
    data_d  = SEG_OFF;
    if (visible) begin
      en_d                 = ~(DIGITS'(1) << idx_q);
      data_d[SEG_DP]       = ~dp_q[idx_q];
      data_d[SEG_G:SEG_A]  = ~seg;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b1;
      nib_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      lz_q    <= 1'b0;
      data_q  <= SEG_OFF;
      en_q    <= '1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      first_q <= 1'b0;
      if (snap) begin
        nib_q   <= datas;
        dp_q    <= dp;
        blank_q <= blank;
        lz_q    <= lz_en;
      end
      data_q  <= data_d;
      en_q    <= en_d;
    end
  end

  assign display_data = data_q;
  assign display_en   = en_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 8-digit and 5-digit instances, short prescaler.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        clr, clrb;
  logic [31:0] datas;
  logic [7:0]  dp, blank;
  logic        lz_en;
  logic [3:0]  brightness;
  logic [7:0]  data_a, en_a;

  logic [19:0] datas_b;
  logic [4:0]  dp_b, blank_b;
  logic [7:0]  data_b;
  logic [4:0]  en_b;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned n_a = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(8), .DIV_W(4), .BRIGHT_W(4)) u_dut (
    .clk          (clk),
    .clr          (clr),
    .datas        (datas),
    .dp           (dp),
    .blank        (blank),
    .lz_en        (lz_en),
    .brightness   (brightness),
    .display_data (data_a),
    .display_en   (en_a)
  );

  seg_scan_ctrl #(.DIGITS(5), .DIV_W(4), .BRIGHT_W(4)) u_dut5 (
    .clk          (clk),
    .clr          (clrb),
    .datas        (datas_b),
    .dp           (dp_b),
    .blank        (blank_b),
    .lz_en        (1'b0),
    .brightness   (4'hF),
    .display_data (data_b),
    .display_en   (en_b)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s (cycle %0d): got %h want %h", tag, n_a, got, want);
    end
  endtask

  // Slot s = (n-1)/16, phase p = (n-1)%16 of the cycle whose output appears after edge n.
  task automatic run_a(input int unsigned cycles, input logic [7:0][7:0] exp_d,
                       input logic [7:0] vis, input logic [3:0] br, input string tag);
    int unsigned s, p;
    logic        lit;
    logic [7:0]  e_en, e_d;
    for (int unsigned c = 0; c < cycles; c++) begin
      @(posedge clk);
      n_a++;
      @(negedge clk);
      s    = ((n_a - 1) / 16) % 8;
      p    = (n_a - 1) % 16;
      lit  = (p != 0) && vis[s] && ((br == 4'hF) || (p < br));
      e_en = lit ? ~(8'h01 << s) : 8'hFF;
      e_d  = lit ? exp_d[s] : 8'hFF;
      chk({tag, "_en"},  {8'h00, en_a},   {8'h00, e_en});
      chk({tag, "_dat"}, {8'h00, data_a}, {8'h00, e_d});
    end
  endtask

  localparam logic [7:0][7:0] SCAN = {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
  localparam logic [7:0][7:0] ALLF = {8{8'h8E}};
  localparam logic [7:0][7:0] LZT  = {8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hFF, 8'hFF, 8'h88, 8'hC0};
  localparam logic [4:0][7:0] TB5  = {8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};

  initial begin
    int unsigned s, p;
    logic        lit;
    logic [4:0]  e_en5;
    logic [7:0]  e_d5;

    clr = 1'b1; clrb = 1'b1;
    datas = 32'h0123_4567; dp = '0; blank = '0; lz_en = 1'b0; brightness = 4'hF;
    datas_b = 20'h4_3210; dp_b = '0; blank_b = 5'b00100;

    repeat (3) @(negedge clk);
    chk("rst_en",   {8'h00, en_a},   16'h00FF);
    chk("rst_dat",  {8'h00, data_a}, 16'h00FF);
    chk("rst5_en",  {11'h0, en_b},   16'h001F);
    chk("rst5_dat", {8'h00, data_b}, 16'h00FF);

    clr = 1'b0;
    n_a = 0;
    run_a(128, SCAN, 8'hFF, 4'hF, "scan");
    run_a(53, SCAN, 8'hFF, 4'hF, "snap_pre");
    datas = 32'hFFFF_FFFF;
    run_a(75, SCAN, 8'hFF, 4'hF, "snap_old");
    run_a(128, ALLF, 8'hFF, 4'hF, "snap_new");

    run_a(37, ALLF, 8'hFF, 4'hF, "pre_rst");
    #2 clr = 1'b1;
    #1;
    chk("async_en",  {8'h00, en_a},   16'h00FF);
    chk("async_dat", {8'h00, data_a}, 16'h00FF);

    datas = 32'h0000_00A0; lz_en = 1'b1; dp = '0;
    @(negedge clk);
    clr = 1'b0;
    n_a = 0;
    run_a(120, LZT, 8'h03, 4'hF, "lz");
    dp = 8'h10;
    run_a(8, LZT, 8'h03, 4'hF, "lz_tail");
    run_a(128, LZT, 8'h13, 4'hF, "lz_dp");
    brightness = 4'd4;
    run_a(128, LZT, 8'h13, 4'd4, "pwm4");
    brightness = 4'd0;
    run_a(128, LZT, 8'h13, 4'd0, "pwm0");

    clrb = 1'b0;
    for (int unsigned n = 1; n <= 160; n++) begin
      @(posedge clk);
      @(negedge clk);
      s     = ((n - 1) / 16) % 5;
      p     = (n - 1) % 16;
      lit   = (p != 0) && (s != 2);
      e_en5 = lit ? ~(5'b00001 << s) : 5'b11111;
      e_d5  = lit ? TB5[s] : 8'hFF;
      chk("d5_en",  {11'h0, en_b},   {11'h0, e_en5});
      chk("d5_dat", {8'h00, data_b}, {8'h00, e_d5});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
